// File: rtl/uart_img_pkg.sv
// Shared types and default geometry for the UART image loader.
package uart_img_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
  localparam int CLKS_PER_BIT_D = 4;
  localparam int IMG_W_D        = 28;
  localparam int IMG_H_D        = 28;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling FSM, LSB-first shifter.
module uart_rx_byte
  import uart_img_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_error
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta, rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_tick;

  assign bit_tick = (cnt == FULL_M1);
  // Combinational so the byte commits on the same edge that samples the stop bit.
  assign byte_valid = (state == STOP) && bit_tick && rx_s;
  assign byte_out   = shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_error <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
        end
        DATA: begin
          if (bit_tick) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
        end
        STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            if (rx_s) state <= IDLE;
            else begin
              frame_error <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else cnt <= cnt + 1'b1;
        end
        WAIT_IDLE: if (rx_s) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_image_loader.sv
// UART-fed ping-pong frame buffer; consumer reads the oldest complete frame by address.
module uart_image_loader
  import uart_img_pkg::*;
#(
  parameter  int CLKS_PER_BIT = CLKS_PER_BIT_D,
  parameter  int IMG_W        = IMG_W_D,
  parameter  int IMG_H        = IMG_H_D,
  parameter  int DATA_W       = 8,
  localparam int DEPTH        = IMG_W * IMG_H,
  localparam int ADDR_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              read_request,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_release,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_data,
  output logic              image_written,
  output logic              read_enable,
  output logic              frame_error,
  output logic              overrun
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic [DATA_W-1:0] mem [2][DEPTH];
  logic              wr_buf, rd_buf;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        full, full_nx;
  logic              accept, last, release_ok, rd_ok;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_out   (rx_byte),
    .byte_valid (rx_valid),
    .frame_error(frame_error)
  );

  // Drop decision uses the pre-release flags: a buffer freed this cycle is usable next cycle.
  assign accept        = rx_valid && !full[wr_buf];
  assign last          = (wr_addr == ADDR_W'(DEPTH - 1));
  assign release_ok    = rd_release && full[rd_buf];
  assign image_written = full[rd_buf];
  assign read_enable   = read_request && image_written;
  assign rd_ok         = read_enable && (addr < ADDR_W'(DEPTH));

  always_comb begin
    full_nx = full;
    if (release_ok)     full_nx[rd_buf] = 1'b0;
    if (accept && last) full_nx[wr_buf] = 1'b1;
  end

  always_ff @(posedge clk)
    if (accept) mem[wr_buf][wr_addr[IDX_W-1:0]] <= rx_byte[DATA_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_buf     <= 1'b0;
      rd_buf     <= 1'b0;
      wr_addr    <= '0;
      full       <= '0;
      overrun    <= 1'b0;
      valid_data <= 1'b0;
      data_out   <= '0;
    end else begin
      full       <= full_nx;
      overrun    <= rx_valid && full[wr_buf];
      if (release_ok) rd_buf <= ~rd_buf;
      if (accept) begin
        if (last) begin
          wr_addr <= '0;
          wr_buf  <= ~wr_buf;
        end else wr_addr <= wr_addr + 1'b1;
      end
      valid_data <= rd_ok;
      data_out   <= rd_ok ? mem[rd_buf][addr[IDX_W-1:0]] : '0;
    end
  end
endmodule

// File: tb/tb_uart_image_loader.sv
// Directed bench: 28x28 full frame on one instance, 4x1 ping-pong/overrun/framing/reset on another.
module tb_uart_image_loader;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       rx_a = 1'b1, rd_req_a = 1'b0, rel_a = 1'b0;
  logic [2:0] addr_a = '0;
  logic [7:0] dout_a;
  logic       vld_a, iw_a, ren_a, fe_a, ovr_a;

  logic       rx_b = 1'b1, rd_req_b = 1'b0, rel_b = 1'b0;
  logic [9:0] addr_b = '0;
  logic [7:0] dout_b;
  logic       vld_b, iw_b, ren_b, fe_b, ovr_b;

  int checks = 0, failures = 0;
  int fe_cnt = 0, ovr_cnt = 0;

  uart_image_loader #(.CLKS_PER_BIT(CPB), .IMG_W(4), .IMG_H(1), .DATA_W(8)) u_small (
    .clk(clk), .reset(reset), .rx(rx_a), .read_request(rd_req_a), .addr(addr_a),
    .rd_release(rel_a), .data_out(dout_a), .valid_data(vld_a), .image_written(iw_a),
    .read_enable(ren_a), .frame_error(fe_a), .overrun(ovr_a));

  uart_image_loader #(.CLKS_PER_BIT(CPB), .IMG_W(28), .IMG_H(28), .DATA_W(8)) u_big (
    .clk(clk), .reset(reset), .rx(rx_b), .read_request(rd_req_b), .addr(addr_b),
    .rd_release(rel_b), .data_out(dout_b), .valid_data(vld_b), .image_written(iw_b),
    .read_enable(ren_b), .frame_error(fe_b), .overrun(ovr_b));

  always @(negedge clk) begin
    if (fe_a)  fe_cnt  <= fe_cnt + 1;
    if (ovr_a) ovr_cnt <= ovr_cnt + 1;
  end

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 5);
  endfunction

  task automatic send_byte(input bit big, input logic [7:0] b, input bit stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (big) rx_b = fr[i]; else rx_a = fr[i];
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  task automatic send4(input logic [7:0] a0, a1, a2, a3);
    send_byte(0, a0, 1); send_byte(0, a1, 1); send_byte(0, a2, 1); send_byte(0, a3, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic rd_a(input logic [2:0] a, output logic v, output logic [7:0] d);
    @(negedge clk); rd_req_a = 1'b1; addr_a = a;
    @(posedge clk); #1; v = vld_a; d = dout_a;
    @(negedge clk); rd_req_a = 1'b0;
  endtask

  task automatic release_a();
    @(negedge clk); rel_a = 1'b1;
    @(negedge clk); rel_a = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_req_a = 1'b1; rd_req_b = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({vld_a, iw_a, ren_a, fe_a, ovr_a, dout_a} !== 13'd0) begin
      failures++; $display("FAIL reset_small got=%h exp=0", {vld_a, iw_a, ren_a, fe_a, ovr_a, dout_a});
    end
    checks++;
    if ({vld_b, iw_b, ren_b, fe_b, ovr_b, dout_b} !== 13'd0) begin
      failures++; $display("FAIL reset_big got=%h exp=0", {vld_b, iw_b, ren_b, fe_b, ovr_b, dout_b});
    end
    rd_req_a = 1'b0; rd_req_b = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < 783; i++) send_byte(1, pat(i), 1);
    checks++;
    if (iw_b !== 1'b0) begin failures++; $display("FAIL big_iw_early got=%b exp=0", iw_b); end
    send_byte(1, pat(783), 1);
    @(negedge clk);
    checks++;
    if (iw_b !== 1'b0) begin failures++; $display("FAIL big_iw_before_stop got=%b exp=0", iw_b); end
    @(posedge clk); #1;
    checks++;
    if (iw_b !== 1'b1) begin failures++; $display("FAIL big_iw_after_stop got=%b exp=1", iw_b); end
    for (int i = 0; i < 784; i++) begin
      @(negedge clk); rd_req_b = 1'b1; addr_b = 10'(i);
      @(posedge clk); #1;
      checks++;
      if (vld_b !== 1'b1 || dout_b !== pat(i)) begin
        failures++; $display("FAIL big_read addr=%0d got=%b/%h exp=1/%h", i, vld_b, dout_b, pat(i));
      end
    end
    @(negedge clk); addr_b = 10'd784;
    @(posedge clk); #1;
    checks++;
    if (vld_b !== 1'b0 || dout_b !== 8'h00) begin
      failures++; $display("FAIL big_addr_oob got=%b/%h exp=0/00", vld_b, dout_b);
    end
    @(negedge clk); rd_req_b = 1'b0;
  endtask

  task automatic test_pingpong();
    logic v; logic [7:0] d;
    send4(8'h12, 8'h34, 8'h56, 8'h78);
    send4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    rd_a(3'd3, v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'h78) begin failures++; $display("FAIL pp_addr3 got=%b/%h exp=1/78", v, d); end
    rd_a(3'd4, v, d);
    checks++;
    if (v !== 1'b0 || d !== 8'h00) begin failures++; $display("FAIL pp_oob got=%b/%h exp=0/00", v, d); end
    @(negedge clk); rd_req_a = 1'b1; #1;
    checks++;
    if (ren_a !== 1'b1) begin failures++; $display("FAIL pp_read_enable got=%b exp=1", ren_a); end
    rd_req_a = 1'b0;
    release_a();
    checks++;
    if (iw_a !== 1'b1) begin failures++; $display("FAIL pp_iw_after_rel got=%b exp=1", iw_a); end
    rd_a(3'd0, v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'hAA) begin failures++; $display("FAIL pp_second_frame got=%b/%h exp=1/AA", v, d); end
    release_a();
    checks++;
    if (iw_a !== 1'b0) begin failures++; $display("FAIL pp_iw_empty got=%b exp=0", iw_a); end
    rd_a(3'd0, v, d);
    checks++;
    if (v !== 1'b0) begin failures++; $display("FAIL pp_read_empty got=%b exp=0", v); end
  endtask

  task automatic test_overrun();
    logic v; logic [7:0] d; int o0;
    o0 = ovr_cnt;
    send4(8'h01, 8'h02, 8'h03, 8'h04);
    send4(8'h11, 8'h12, 8'h13, 8'h14);
    send4(8'h21, 8'h22, 8'h23, 8'h24);
    repeat (2) @(negedge clk);
    checks++;
    if (ovr_cnt - o0 !== 4) begin failures++; $display("FAIL ovr_count got=%0d exp=4", ovr_cnt - o0); end
    rd_a(3'd0, v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'h01) begin failures++; $display("FAIL ovr_frame1 got=%b/%h exp=1/01", v, d); end
    release_a();
    rd_a(3'd3, v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'h14) begin failures++; $display("FAIL ovr_frame2 got=%b/%h exp=1/14", v, d); end
    send4(8'hEE, 8'hEF, 8'hF0, 8'hF1);
    repeat (2) @(negedge clk);
    checks++;
    if (ovr_cnt - o0 !== 4) begin failures++; $display("FAIL ovr_refill_count got=%0d exp=4", ovr_cnt - o0); end
    release_a();
    rd_a(3'd0, v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'hEE) begin failures++; $display("FAIL ovr_refill0 got=%b/%h exp=1/EE", v, d); end
    rd_a(3'd3, v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'hF1) begin failures++; $display("FAIL ovr_refill3 got=%b/%h exp=1/F1", v, d); end
    release_a();
  endtask

  task automatic test_framing();
    logic v; logic [7:0] d; int f0;
    f0 = fe_cnt;
    send_byte(0, 8'h5A, 0);
    @(negedge clk); rx_a = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (fe_cnt - f0 !== 1) begin failures++; $display("FAIL fe_pulse got=%0d exp=1", fe_cnt - f0); end
    send4(8'h33, 8'h44, 8'h55, 8'h66);
    checks++;
    if (iw_a !== 1'b1) begin failures++; $display("FAIL fe_iw got=%b exp=1", iw_a); end
    rd_a(3'd0, v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'h33) begin failures++; $display("FAIL fe_same_addr got=%b/%h exp=1/33", v, d); end
    rd_a(3'd3, v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'h66) begin failures++; $display("FAIL fe_last got=%b/%h exp=1/66", v, d); end
    checks++;
    if (fe_cnt - f0 !== 1) begin failures++; $display("FAIL fe_no_extra got=%0d exp=1", fe_cnt - f0); end
    release_a();
  endtask

  task automatic test_glitch_reset();
    logic v; logic [7:0] d; int f0;
    f0 = fe_cnt;
    @(negedge clk); rx_a = 1'b0;
    @(negedge clk); rx_a = 1'b1;
    repeat (20) @(negedge clk);
    send4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    rd_a(3'd0, v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'hA1) begin failures++; $display("FAIL glitch_addr0 got=%b/%h exp=1/A1", v, d); end
    checks++;
    if (fe_cnt - f0 !== 0) begin failures++; $display("FAIL glitch_fe got=%0d exp=0", fe_cnt - f0); end
    release_a();
    send_byte(0, 8'h77, 1); send_byte(0, 8'h88, 1);
    @(negedge clk); reset = 1'b1; #1;
    checks++;
    if ({vld_a, iw_a, ren_a, fe_a, ovr_a, dout_a} !== 13'd0) begin
      failures++; $display("FAIL midreset_outputs got=%h exp=0", {vld_a, iw_a, ren_a, fe_a, ovr_a, dout_a});
    end
    repeat (2) @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    send4(8'h9A, 8'h9B, 8'h9C, 8'h9D);
    checks++;
    if (iw_a !== 1'b1) begin failures++; $display("FAIL rst_iw got=%b exp=1", iw_a); end
    rd_a(3'd0, v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'h9A) begin failures++; $display("FAIL rst_addr0 got=%b/%h exp=1/9A", v, d); end
    rd_a(3'd3, v, d);
    checks++;
    if (v !== 1'b1 || d !== 8'h9D) begin failures++; $display("FAIL rst_addr3 got=%b/%h exp=1/9D", v, d); end
    release_a();
    checks++;
    if (iw_a !== 1'b0) begin failures++; $display("FAIL rst_single_frame got=%b exp=0", iw_a); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_pingpong();
    test_overrun();
    test_framing();
    test_glitch_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
